fifo_mem_ctrl: RTL and testbench

- Control block that turns the dual-port `memoria` (separate read/write addresses, registered read data) into a synchronous FIFO.
- Generates the write/read strobes and addresses for the memory. Tracks occupancy.
- Flags full/empty, programmable almost-full/almost-empty, and overflow/underflow errors.
- Instantiated beside one `memoria` per queue in the switch datapath. The data bus goes straight to the memory; this block never touches data.

---
 rtl/fifo_mem_ctrl.sv | 69 ++++++
 tb/tb_fifo_mem_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mem_ctrl.sv
// Control block that drives a dual-port memory as a synchronous FIFO:
// strobes, addresses, occupancy and status flags. Data never passes through here.
module fifo_mem_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_LENGTH = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   th_high,
  input  logic [ADDR_WIDTH:0]   th_low,
  output logic                  write,
  output logic                  read,
  output logic [ADDR_WIDTH-1:0] addressW,
  output logic [ADDR_WIDTH-1:0] addressR,
  output logic                  data_valid,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(MEM_LENGTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push_acc;
  logic                  pop_acc;

  // A push into a full FIFO is still legal when a pop frees a slot in the same cycle.
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);

  assign write    = push_acc;
  assign read     = pop_acc;
  assign addressW = wr_ptr;
  assign addressR = rd_ptr;

  assign full         = (fifo_count == FULL_COUNT);
  assign empty        = (fifo_count == '0);
  assign almost_full  = (fifo_count >= th_high);
  assign almost_empty = (fifo_count <= th_low);

  // data_valid lines up with the memory's registered read port, one cycle after the pop.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      error      <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + {{(ADDR_WIDTH-1){1'b0}}, push_acc};
      rd_ptr     <= rd_ptr + {{(ADDR_WIDTH-1){1'b0}}, pop_acc};
      data_valid <= pop_acc;
      case ({push_acc, pop_acc})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if ((push & ~push_acc) | (pop & ~pop_acc))
        error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Self-checking bench for fifo_mem_ctrl: behavioural memory beside the DUT,
// a reference occupancy model and a data scoreboard queue.
module tb_fifo_mem_ctrl;

  logic        clk;
  logic        reset_L;
  logic        push;
  logic        pop;
  logic [4:0]  th_high;
  logic [4:0]  th_low;
  logic        write;
  logic        read;
  logic [3:0]  addressW;
  logic [3:0]  addressR;
  logic        data_valid;
  logic [4:0]  fifo_count;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic        error;

  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [31:0] mem [16];

  int tests_run;
  int tests_failed;

  // reference model state
  int          m_cnt;
  logic [3:0]  m_wp;
  logic [3:0]  m_rp;
  logic        m_err;
  logic        m_dv;
  logic [31:0] m_word;
  logic [31:0] sb [$];

  typedef struct {
    logic       push;
    logic       pop;
    logic [4:0] th_high;
    logic [4:0] th_low;
    int         exp_count;
    logic       exp_af;
    logic       exp_ae;
    logic       exp_err;
  } vec_t;

  vec_t vecs [9];

  fifo_mem_ctrl #(.ADDR_WIDTH(4)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .pop          (pop),
    .th_high      (th_high),
    .th_low       (th_low),
    .write        (write),
    .read         (read),
    .addressW     (addressW),
    .addressR     (addressR),
    .data_valid   (data_valid),
    .fifo_count   (fifo_count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory with registered read data, as the real memory instance behaves
  always @(posedge clk) begin
    if (write) mem[addressW] <= data_in;
    if (read)  data_out <= mem[addressR];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic doReset();
    reset_L = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    m_cnt = 0;
    m_wp  = '0;
    m_rp  = '0;
    m_err = 1'b0;
    m_dv  = 1'b0;
    sb.delete();
  endtask

  task automatic applyStimulus(input logic p_push, input logic p_pop, input logic [31:0] p_data);
    logic pa;
    logic wa;
    @(negedge clk);
    push    = p_push;
    pop     = p_pop;
    data_in = p_data;
    #1;
    pa = p_pop && (m_cnt != 0);
    wa = p_push && ((m_cnt != 16) || pa);
    checkOutput("write", write, wa);
    checkOutput("read", read, pa);
    checkOutput("addressW", addressW, m_wp);
    checkOutput("addressR", addressR, m_rp);
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    if (wa) begin
      sb.push_back(p_data);
      m_wp = m_wp + 4'd1;
    end
    if (pa) begin
      m_word = sb.pop_front();
      m_rp = m_rp + 4'd1;
    end
    m_cnt = m_cnt + (wa ? 1 : 0) - (pa ? 1 : 0);
    if ((p_push && !wa) || (p_pop && !pa)) m_err = 1'b1;
    m_dv = pa;
    checkOutput("fifo_count", fifo_count, m_cnt);
    checkOutput("full", full, m_cnt == 16);
    checkOutput("empty", empty, m_cnt == 0);
    checkOutput("almost_full", almost_full, m_cnt >= int'(th_high));
    checkOutput("almost_empty", almost_empty, m_cnt <= int'(th_low));
    checkOutput("error", error, m_err);
    checkOutput("data_valid", data_valid, m_dv);
    if (m_dv) checkOutput("data_out", data_out, m_word);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_L = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
    th_high = 5'd14;
    th_low  = 5'd0;

    vecs[0] = '{1'b1, 1'b0, 5'd2, 5'd0, 1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 5'd2, 5'd0, 2, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 5'd2, 5'd0, 3, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 5'd2, 5'd0, 4, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 5'd6, 5'd5, 5, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 5'd6, 5'd5, 5, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 5'd0, 5'd16, 5, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 5'd5, 5'd4, 5, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 5'd6, 5'd5, 5, 1'b0, 1'b1, 1'b0};

    // reset and idle
    doReset();
    #1;
    checkOutput("rst empty", empty, 1'b1);
    checkOutput("rst full", full, 1'b0);
    checkOutput("rst fifo_count", fifo_count, 0);
    checkOutput("rst write", write, 1'b0);
    checkOutput("rst read", read, 1'b0);
    checkOutput("rst error", error, 1'b0);
    checkOutput("rst data_valid", data_valid, 1'b0);
    checkOutput("rst addressW", addressW, 0);
    checkOutput("rst addressR", addressR, 0);

    // table vectors: thresholds and push+pop at count 5
    for (int i = 0; i < 9; i++) begin
      th_high = vecs[i].th_high;
      th_low  = vecs[i].th_low;
      applyStimulus(vecs[i].push, vecs[i].pop, 32'hA0 + i);
      checkOutput($sformatf("vec%0d count", i), fifo_count, vecs[i].exp_count);
      checkOutput($sformatf("vec%0d almost_full", i), almost_full, vecs[i].exp_af);
      checkOutput($sformatf("vec%0d almost_empty", i), almost_empty, vecs[i].exp_ae);
      checkOutput($sformatf("vec%0d error", i), error, vecs[i].exp_err);
    end
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // fill to capacity
    doReset();
    th_high = 5'd14;
    th_low  = 5'd0;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 1'b0, i);
      checkOutput("fill almost_full", almost_full, i >= 14);
    end
    checkOutput("fill full", full, 1'b1);
    checkOutput("fill count", fifo_count, 16);
    applyStimulus(1'b1, 1'b1, 32'h11);
    checkOutput("full push+pop count", fifo_count, 16);
    checkOutput("full push+pop error", error, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h99);
    checkOutput("overflow error", error, 1'b1);

    // drain; scoreboard checks words 2..17 and back-to-back data_valid
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("drain empty", empty, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0);

    // underflow on its own
    doReset();
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("underflow error", error, 1'b1);

    // push+pop on empty: only push taken
    doReset();
    applyStimulus(1'b1, 1'b1, 32'h55);
    checkOutput("empty push+pop count", fifo_count, 1);
    checkOutput("empty push+pop error", error, 1'b1);

    // wrap-around
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'h100 + i);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'h200 + i);
    checkOutput("wrap count", fifo_count, 10);
    checkOutput("wrap addressW", addressW, 4);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("wrap addressR", addressR, 4);
    checkOutput("wrap error", error, 1'b0);

    // asynchronous reset with a pop in flight
    doReset();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 32'h300 + i);
    @(negedge clk);
    pop = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("pre-reset data_valid", data_valid, 1'b1);
    checkOutput("pre-reset count", fifo_count, 6);
    #2;
    reset_L = 1'b0;
    #1;
    checkOutput("async count", fifo_count, 0);
    checkOutput("async empty", empty, 1'b1);
    checkOutput("async full", full, 1'b0);
    checkOutput("async read", read, 1'b0);
    checkOutput("async write", write, 1'b0);
    checkOutput("async addressW", addressW, 0);
    checkOutput("async addressR", addressR, 0);
    checkOutput("async data_valid", data_valid, 1'b0);
    checkOutput("async error", error, 1'b0);
    pop = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post-edge data_valid", data_valid, 1'b0);
    doReset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
